hub_nport: RTL and testbench



---
 rtl/hub_pkg.sv | 18 +
 rtl/hub_frame_fifo.sv | 97 +++++++++
 rtl/hub_nport.sv | 101 ++++++++++
 tb/tb_hub_nport.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hub_pkg.sv
// Shared types and width helpers for the N-port repeater hub.
package hub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XMIT = 1'b1
  } state_e;

  // Pointer width carries one extra wrap bit so full and empty can be told apart.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int port_w(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/hub_frame_fifo.sv
// Store-and-forward frame FIFO for one hub port. Bytes are written speculatively and
// committed on the last byte, or rolled back when the frame overflowed.
module hub_frame_fifo
  import hub_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_last_i,
  input  logic              rd_pop_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_last_o,
  output logic              has_frame_o,
  output logic              drop_pulse_o
);

  localparam int PTR_W  = ptr_w(FIFO_DEPTH);
  localparam int ADDR_W = PTR_W - 1;

  logic [DATA_W:0]   mem_q [FIFO_DEPTH];
  logic [DATA_W:0]   rd_word_q;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  cmt_ptr_q, cmt_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  cnt_q, cnt_d;
  logic              drop_q, drop_d;
  logic              pulse_q, pulse_d;
  logic              wr_en, commit, full;

  // Occupancy counts the uncommitted tail, so a runaway frame cannot eat committed data.
  assign full = (wr_ptr_q - rd_ptr_q) == PTR_W'(FIFO_DEPTH);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    drop_d    = drop_q;
    pulse_d   = 1'b0;
    wr_en     = 1'b0;
    commit    = 1'b0;
    if (wr_valid_i) begin
      if (drop_q || full) begin
        if (wr_last_i) begin
          wr_ptr_d = cmt_ptr_q;
          drop_d   = 1'b0;
          pulse_d  = 1'b1;
        end else begin
          drop_d = 1'b1;
        end
      end else begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (wr_last_i) begin
          cmt_ptr_d = wr_ptr_q + PTR_W'(1);
          commit    = 1'b1;
        end
      end
    end
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_pop_i);
    cnt_d    = cnt_q + PTR_W'(commit) - PTR_W'(rd_pop_i & rd_word_q[DATA_W]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      cmt_ptr_q <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      drop_q    <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cmt_ptr_q <= cmt_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      drop_q    <= drop_d;
      pulse_q   <= pulse_d;
    end
  end

  // Read register prefetches the next head; it is only consumed once a frame is committed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= {wr_last_i, wr_data_i};
    end
    rd_word_q <= mem_q[rd_ptr_d[ADDR_W-1:0]];
  end

  assign rd_data_o    = rd_word_q[DATA_W-1:0];
  assign rd_last_o    = rd_word_q[DATA_W];
  assign has_frame_o  = (cnt_q != '0);
  assign drop_pulse_o = pulse_q;

endmodule

// File: rtl/hub_nport.sv
// N-port repeater hub: round-robin picks one buffered frame and repeats it in lockstep
// to every port except its source.
module hub_nport
  import hub_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*DATA_W-1:0] rx_data,
  input  logic [NUM_PORTS-1:0]        rx_valid,
  input  logic [NUM_PORTS-1:0]        rx_last,
  output logic [NUM_PORTS*DATA_W-1:0] tx_data,
  output logic [NUM_PORTS-1:0]        tx_valid,
  output logic [NUM_PORTS-1:0]        tx_last,
  input  logic [NUM_PORTS-1:0]        tx_ready,
  output logic [NUM_PORTS-1:0]        drop_pulse
);

  localparam int PORT_W = port_w(NUM_PORTS);

  state_e              state_q;
  logic [PORT_W-1:0]   src_q, rr_q, grant_idx, rr_next;
  logic                grant_found;
  int                  idx;
  logic [NUM_PORTS-1:0] has_frame, head_last_v, src_mask, fifo_pop;
  logic [DATA_W-1:0]   head_data_a [NUM_PORTS];
  logic [DATA_W-1:0]   head_data;
  logic                head_last, xmit, pop;

  assign xmit      = (state_q == XMIT);
  assign src_mask  = NUM_PORTS'(1) << src_q;
  assign head_data = head_data_a[src_q];
  assign head_last = head_last_v[src_q];
  // The byte advances only when every destination can take it, keeping ports in lockstep.
  assign pop       = xmit & (&(tx_ready | src_mask));

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      hub_frame_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .wr_valid_i   (rx_valid[gi]),
        .wr_data_i    (rx_data[gi*DATA_W +: DATA_W]),
        .wr_last_i    (rx_last[gi]),
        .rd_pop_i     (fifo_pop[gi]),
        .rd_data_o    (head_data_a[gi]),
        .rd_last_o    (head_last_v[gi]),
        .has_frame_o  (has_frame[gi]),
        .drop_pulse_o (drop_pulse[gi])
      );
      assign fifo_pop[gi]                   = pop & src_mask[gi];
      assign tx_valid[gi]                   = xmit & ~src_mask[gi];
      assign tx_last[gi]                    = xmit & ~src_mask[gi] & head_last;
      assign tx_data[gi*DATA_W +: DATA_W]   = xmit ? head_data : '0;
    end
  endgenerate

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!grant_found && has_frame[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PORT_W'(idx);
      end
    end
    rr_next = (int'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + PORT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      rr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            src_q   <= grant_idx;
            rr_q    <= rr_next;
            state_q <= XMIT;
          end
        end
        XMIT: begin
          if (pop && head_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub_nport.sv
// Self-checking bench for hub_nport: 4 ports, 8-entry FIFOs, scoreboard of expected beats.
module tb_hub_nport;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rx_data;
  logic [3:0]  rx_valid, rx_last;
  logic [31:0] tx_data;
  logic [3:0]  tx_valid, tx_last, tx_ready, drop_pulse;

  hub_nport #(.NUM_PORTS(4), .DATA_W(8), .FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_last    (rx_last),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready),
    .drop_pulse (drop_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] src;
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    int         src;
    int         len;
    logic [7:0] base;
    logic [3:0] exp_drop;
  } vec_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    beats_seen = 0;
  bit    mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rx();
    rx_data  = '0;
    rx_valid = '0;
    rx_last  = '0;
  endtask

  task automatic set_byte(input int p, input logic [7:0] d, input logic l, input bit push);
    beat_t b;
    rx_data[p*8 +: 8] = d;
    rx_valid[p]       = 1'b1;
    rx_last[p]        = l;
    if (push) begin
      b.src  = 2'(p);
      b.data = d;
      b.last = l;
      exp_q.push_back(b);
    end
  endtask

  // Presents one byte per cycle; returns in the cycle after the last byte.
  task automatic drive_frame(input int p, input int len, input logic [7:0] base, input bit push);
    for (int i = 0; i < len; i++) begin
      set_byte(p, 8'(base + i), (i == len - 1), push);
      step();
      clear_rx();
    end
  endtask

  task automatic wait_drain(input int bound);
    int k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      step();
      k++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic wait_beats(input int target, input int bound);
    int k = 0;
    while (beats_seen < target && k < bound) begin
      step();
      k++;
    end
    check("beats_reached", beats_seen >= target, 1);
  endtask

  // Scoreboard: every cycle with traffic is compared against the oldest expected beat.
  always @(negedge clk) begin : mon
    beat_t      e;
    logic [3:0] vm;
    if (!reset && mon_en && tx_valid != 4'h0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_tx", tx_valid, 4'h0);
      end else begin
        e  = exp_q[0];
        vm = ~(4'b0001 << e.src);
        check("tx_valid", tx_valid, vm);
        check("tx_data", tx_data, {4{e.data}});
        check("tx_last", tx_last, e.last ? vm : 4'h0);
        if (&(tx_ready | ~vm)) begin
          void'(exp_q.pop_front());
          beats_seen++;
          $display("beat src=%0d data=%02h last=%0d", e.src, e.data, e.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[7];
    logic [3:0] gap_exp[7];
    int         base;

    vecs[0] = '{src: 1, len: 2,  base: 8'h10, exp_drop: 4'b0000};
    vecs[1] = '{src: 3, len: 5,  base: 8'h30, exp_drop: 4'b0000};
    vecs[2] = '{src: 2, len: 8,  base: 8'h50, exp_drop: 4'b0000};
    vecs[3] = '{src: 1, len: 10, base: 8'h70, exp_drop: 4'b0010};
    vecs[4] = '{src: 1, len: 4,  base: 8'h90, exp_drop: 4'b0000};
    vecs[5] = '{src: 0, len: 1,  base: 8'hC0, exp_drop: 4'b0000};
    vecs[6] = '{src: 3, len: 9,  base: 8'hE0, exp_drop: 4'b1000};
    gap_exp = '{4'h0, 4'b1101, 4'h0, 4'b1011, 4'h0, 4'b0111, 4'h0};

    reset    = 1'b1;
    tx_ready = 4'hF;
    clear_rx();
    step();
    step();
    @(negedge clk);
    check("rst_tx_valid", tx_valid, 4'h0);
    check("rst_tx_last", tx_last, 4'h0);
    check("rst_tx_data", tx_data, 32'h0);
    check("rst_drop", drop_pulse, 4'h0);
    step();
    reset  = 1'b0;
    mon_en = 1'b1;
    step();

    // Port 0 three-byte frame: first tx_valid two cycles after the last byte.
    drive_frame(0, 3, 8'hA1, 1'b1);
    @(negedge clk);
    check("lat_cycle1", tx_valid, 4'h0);
    step();
    @(negedge clk);
    check("lat_cycle2", tx_valid, 4'b1110);
    check("lat_data", tx_data, {4{8'hA1}});
    wait_drain(20);
    repeat (2) step();

    // Ports 1..3 commit single-byte frames together: round-robin order, one idle cycle apart.
    set_byte(1, 8'hB1, 1'b1, 1'b1);
    set_byte(2, 8'hB2, 1'b1, 1'b1);
    set_byte(3, 8'hB3, 1'b1, 1'b1);
    step();
    clear_rx();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("rr_gap", tx_valid, gap_exp[i]);
      step();
    end
    wait_drain(20);
    repeat (2) step();

    // Backpressure on port 0 during a port-2 frame.
    base = beats_seen;
    drive_frame(2, 4, 8'h40, 1'b1);
    wait_beats(base + 1, 20);
    tx_ready = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_valid", tx_valid, 4'b1011);
      check("stall_data", tx_data, {4{8'h41}});
      check("stall_nopop", beats_seen, base + 1);
      step();
    end
    tx_ready = 4'hF;
    wait_drain(20);
    repeat (2) step();

    for (int v = 0; v < 7; v++) begin
      drive_frame(vecs[v].src, vecs[v].len, vecs[v].base, vecs[v].exp_drop == 4'h0);
      @(negedge clk);
      check("drop_pulse", drop_pulse, vecs[v].exp_drop);
      step();
      @(negedge clk);
      check("drop_clear", drop_pulse, 4'h0);
      wait_drain(40);
      repeat (3) step();
    end

    // New frame on port 0 commits in the same cycle its previous frame's last byte pops.
    drive_frame(0, 3, 8'h61, 1'b1);
    step();
    step();
    step();
    set_byte(0, 8'h6F, 1'b1, 1'b1);
    @(negedge clk);
    check("same_cycle_last", tx_last, 4'b1110);
    step();
    clear_rx();
    @(negedge clk);
    check("same_cycle_gap", tx_valid, 4'h0);
    step();
    @(negedge clk);
    check("same_cycle_regrant", tx_valid, 4'b1110);
    check("same_cycle_data", tx_data, {4{8'h6F}});
    wait_drain(20);
    repeat (2) step();

    // Reset after the second byte of a five-byte frame.
    base = beats_seen;
    drive_frame(1, 5, 8'h51, 1'b1);
    wait_beats(base + 2, 20);
    reset = 1'b1;
    step();
    @(negedge clk);
    check("midrst_valid", tx_valid, 4'h0);
    check("midrst_last", tx_last, 4'h0);
    exp_q.delete();
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_frames", tx_valid, 4'h0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
